// File: rtl/reset_seq_pkg.sv
// +---------------------------------------------------------------------------+
// | reset_seq_pkg : shared types and helpers for the reset_sequencer block     |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

package reset_seq_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    POR_WAIT = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    SHUTDOWN = 2'd3
  } seq_state_e;

  // Wide enough to hold the larger of the two delays.
  function automatic int unsigned cnt_width(input int unsigned por, input int unsigned gap);
    int unsigned m;
    m = (por > gap) ? por : gap;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_delay_cnt.sv
// +---------------------------------------------------------------------------+
// | seq_delay_cnt : delay counter shared by POR, release and shutdown waits    |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module seq_delay_cnt #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk40,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Hit on the edge the count would reach the terminal value; it restarts at 0.
  assign hit_o   = run_i && (cnt_inc == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || hit_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// +---------------------------------------------------------------------------+
// | reset_sequencer : staggered power-on / soft-restart enable sequencer       |
// | Optional macro  : REVERSE_SHUTDOWN_EN (reverse-order channel shutdown)     |
// | Revision        : 1.0                                                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned POR_CYCLES = 62,
  parameter int unsigned STAGE_GAP  = 16
) (
  input  logic                clk40,
  input  logic                rst,
  input  logic                req,
  input  logic                hold,
  output logic [CHANNELS-1:0] en,
  output logic                done
);

  localparam int unsigned      CNT_W      = cnt_width(POR_CYCLES, STAGE_GAP);
  localparam int unsigned      STG_W      = $clog2(MAX_CHANNELS + 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] POR_TERM   = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'(STAGE_GAP);

  seq_state_e          state_q, state_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic                done_q, done_d;
  logic [STG_W-1:0]    stage_q, stage_d;

  logic             cnt_clear;
  logic             cnt_run;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_hit;

  // Kept outside the FSM process so the hit path has no feedback through it.
  assign cnt_run  = !hold && (state_q != RUN);
  assign cnt_term = (state_q == POR_WAIT) ? POR_TERM : GAP_TERM;

  seq_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk40   (clk40),
    .rst     (rst),
    .clear_i (cnt_clear),
    .run_i   (cnt_run),
    .term_i  (cnt_term),
    .hit_o   (cnt_hit)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    done_d    = done_q;
    stage_d   = stage_q;
    cnt_clear = 1'b0;

    unique case (state_q)
      POR_WAIT: begin
        if (cnt_hit) begin
          en_d    = CHANNELS'(1);
          stage_d = STG_W'(1);
          if (CHANNELS == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (cnt_hit) begin
          en_d    = (en_q << 1) | CHANNELS'(1);
          stage_d = stage_q + STG_W'(1);
          if (stage_q == LAST_STAGE) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
      end
      SHUTDOWN: begin
`ifdef REVERSE_SHUTDOWN_EN
        if (cnt_hit) begin
          en_d = en_q >> 1;
          if ((en_q >> 1) == '0) begin
            state_d = POR_WAIT;
            stage_d = '0;
          end
        end
`else
        state_d = POR_WAIT;
`endif
      end
      default: state_d = POR_WAIT;
    endcase

    if (req && (state_q != SHUTDOWN)) begin
      cnt_clear = 1'b1;
      done_d    = 1'b0;
      stage_d   = '0;
`ifdef REVERSE_SHUTDOWN_EN
      // The top channel drops on the request edge; the rest follow STAGE_GAP apart.
      en_d    = en_q >> 1;
      state_d = ((en_q >> 1) == '0) ? POR_WAIT : SHUTDOWN;
`else
      en_d    = '0;
      state_d = POR_WAIT;
`endif
    end
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      state_q <= POR_WAIT;
      en_q    <= '0;
      done_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      done_q  <= done_d;
      stage_q <= stage_d;
    end
  end

  assign en   = en_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// +---------------------------------------------------------------------------+
// | tb_reset_sequencer : self-checking bench for reset_sequencer               |
// | Optional macro     : REVERSE_SHUTDOWN_EN (must match the RTL build)        |
// | Revision           : 1.0                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module tb_reset_sequencer;

  localparam int CH  = 4;
  localparam int POR = 62;
  localparam int GAP = 16;

  logic          clk40 = 1'b0;
  logic          rst   = 1'b1;
  logic          req   = 1'b0;
  logic          hold  = 1'b0;
  logic [CH-1:0] en;
  logic          done;
  logic [0:0]    en1;
  logic          done1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: e = non-held edges since (re)start; channels on = f(e).
  int m_e     = 0;
  int m_cnt   = 0;
  int m_sd    = 0;
  int m_sd_e  = 0;

  always #12.5 clk40 = ~clk40;

  reset_sequencer #(.CHANNELS(CH), .POR_CYCLES(POR), .STAGE_GAP(GAP)) dut (
    .clk40 (clk40), .rst (rst), .req (req), .hold (hold), .en (en), .done (done)
  );

  reset_sequencer #(.CHANNELS(1), .POR_CYCLES(1), .STAGE_GAP(1)) dut1 (
    .clk40 (clk40), .rst (rst), .req (req), .hold (hold), .en (en1), .done (done1)
  );

  function automatic int chans_for(input int e);
    int c;
    if (e < POR) return 0;
    c = 1 + (e - POR) / GAP;
    return (c > CH) ? CH : c;
  endfunction

  function automatic logic [CH-1:0] exp_en();
    return CH'((1 << m_cnt) - 1);
  endfunction

  function automatic logic exp_done();
    return (m_cnt == CH) && (m_sd == 0);
  endfunction

  task automatic model_step(input logic r, input logic q, input logic h);
    if (r) begin
      m_e = 0; m_cnt = 0; m_sd = 0; m_sd_e = 0;
    end else if (m_sd != 0) begin
      if (!h) begin
        m_sd_e++;
        if (m_sd_e == GAP) begin
          m_sd_e = 0;
          m_cnt--;
          if (m_cnt == 0) begin m_sd = 0; m_e = 0; end
        end
      end
    end else if (q) begin
`ifdef REVERSE_SHUTDOWN_EN
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt > 0) begin m_sd = 1; m_sd_e = 0; end
        else m_e = 0;
      end else begin
        m_e = 0;
      end
`else
      m_e = 0; m_cnt = 0;
`endif
    end else begin
      if (m_cnt < CH && !h) m_e++;
      m_cnt = chans_for(m_e);
    end
  endtask

  task automatic tick(input logic r, input logic q, input logic h);
    rst = r; req = q; hold = h;
    @(posedge clk40);
    model_step(r, q, h);
    #1;
  endtask

  task automatic test_reset();
    logic [CH-1:0] spec_en;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (en !== 4'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: en=%h done=%b, want en=0 done=0", en, done);
    end
    for (int k = 1; k <= 115; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      spec_en = (k < 62) ? 4'h0 : (k < 78) ? 4'h1 : (k < 94) ? 4'h3 : (k < 110) ? 4'h7 : 4'hF;
      n_tests++;
      if (en !== spec_en || done !== (k >= 110)) begin
        n_fail++;
        $display("FAIL por_timeline edge %0d: en=%h done=%b, want en=%h done=%b", k, en, done, spec_en, (k >= 110));
      end
      n_tests++;
      if (en !== exp_en() || done !== exp_done()) begin
        n_fail++;
        $display("FAIL por_model edge %0d: en=%h done=%b, want en=%h done=%b", k, en, done, exp_en(), exp_done());
      end
    end
  endtask

  task automatic test_hold();
    logic [CH-1:0] spec_en;
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 125; k++) begin
      tick(1'b0, 1'b0, (k >= 31 && k <= 40));
      spec_en = (k < 72) ? 4'h0 : (k < 88) ? 4'h1 : (k < 104) ? 4'h3 : (k < 120) ? 4'h7 : 4'hF;
      n_tests++;
      if (en !== spec_en || done !== (k >= 120) || en !== exp_en()) begin
        n_fail++;
        $display("FAIL hold_shift edge %0d: en=%h done=%b, want en=%h done=%b", k, en, done, spec_en, (k >= 120));
      end
    end
    // hold in RUN must not disturb anything
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (en !== 4'hF || done !== 1'b1) begin
      n_fail++; $display("FAIL hold_in_run: en=%h done=%b, want en=F done=1", en, done);
    end
  endtask

  task automatic test_req();
    logic [CH-1:0] spec_en;
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 112; k++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
`ifdef REVERSE_SHUTDOWN_EN
    n_tests++;
    if (en !== 4'h7 || done !== 1'b0) begin
      n_fail++; $display("FAIL req_shutdown_entry: en=%h done=%b, want en=7 done=0", en, done);
    end
    for (int k = 1; k <= 112; k++) begin
      tick(1'b0, (k == 20), 1'b0);
      spec_en = (k < 16) ? 4'h7 : (k < 32) ? 4'h3 : (k < 48) ? 4'h1 : (k < 110) ? 4'h0 : 4'h1;
      n_tests++;
      if (en !== spec_en || done !== 1'b0 || en !== exp_en()) begin
        n_fail++;
        $display("FAIL req_shutdown edge %0d: en=%h done=%b, want en=%h done=0", k, en, done, spec_en);
      end
    end
`else
    n_tests++;
    if (en !== 4'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL req_clear: en=%h done=%b, want en=0 done=0", en, done);
    end
    for (int k = 1; k <= 64; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      spec_en = (k < 62) ? 4'h0 : 4'h1;
      n_tests++;
      if (en !== spec_en || done !== 1'b0 || en !== exp_en()) begin
        n_fail++;
        $display("FAIL req_restart edge %0d: en=%h done=%b, want en=%h done=0", k, en, done, spec_en);
      end
    end
`endif
  endtask

  task automatic test_rst_req();
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 80; k++) tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (en !== 4'h3) begin
      n_fail++; $display("FAIL rst_req_setup: en=%h, want en=3", en);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (en !== 4'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_beats_req: en=%h done=%b, want en=0 done=0", en, done);
    end
    for (int k = 1; k <= 63; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (en !== ((k < 62) ? 4'h0 : 4'h1)) begin
        n_fail++; $display("FAIL rst_req_restart edge %0d: en=%h, want en=%h", k, en, ((k < 62) ? 4'h0 : 4'h1));
      end
    end
  endtask

  task automatic test_single_channel();
    tick(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (en1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL ch1_reset: en=%b done=%b, want en=0 done=0", en1, done1);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (en1 !== 1'b1 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL ch1_edge1: en=%b done=%b, want en=1 done=1", en1, done1);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (en1 !== 1'b1 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL ch1_stay: en=%b done=%b, want en=1 done=1", en1, done1);
    end
  endtask

  task automatic test_random();
    logic r, q, h;
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 399) == 0);
      q = ($urandom_range(0, 249) == 0) || (k % 700 == 350);
      h = ($urandom_range(0, 99) < 15);
      tick(r, q, h);
      n_tests++;
      if (en !== exp_en() || done !== exp_done()) begin
        n_fail++;
        $display("FAIL random cycle %0d: en=%h done=%b, want en=%h done=%b", k, en, done, exp_en(), exp_done());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_req();
    test_rst_req();
    test_single_channel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
